// File: rtl/sprite_pos_regs.sv
// Sprite position register bank with vsync-committed shadow copy and frame counter.
// Define SPRITE_SHADOW_EN for double buffering; otherwise outputs follow the active bank.
module sprite_pos_regs #(
    parameter int POS_W  = 11,
    parameter int FCNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             vsync,
    output logic [POS_W-1:0] posx1,
    output logic [POS_W-1:0] posy1,
    output logic [POS_W-1:0] posx2,
    output logic [POS_W-1:0] posy2,
    output logic [POS_W-1:0] posx3,
    output logic [POS_W-1:0] posy3,
    output logic [POS_W-1:0] posx4,
    output logic [POS_W-1:0] posy4,
    output logic [POS_W-1:0] posx5,
    output logic [POS_W-1:0] posy5
);
    localparam int NREG = 10;

    logic [POS_W-1:0]  act_q [NREG];
    logic [POS_W-1:0]  pos   [NREG];
    logic              sync1_q;
    logic              sync2_q;
    logic              hist_q;
    logic              vs_fall;
    logic [FCNT_W-1:0] fcnt_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              pend_rd;
    logic              unused_wdata;

    assign unused_wdata = ^wdata[31:POS_W];

    // vsync crosses from the pixel domain; idle level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign vs_fall = hist_q & ~sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
        end else if (vs_fall) begin
            fcnt_q <= fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                act_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we && addr == 4'(i)) begin
                    act_q[i] <= wdata[POS_W-1:0];
                end
            end
        end
    end

`ifdef SPRITE_SHADOW_EN
    logic [POS_W-1:0] shd_q [NREG];
    logic             pend_q;
    logic             commit;

    assign commit = we && addr == 4'd10 && wdata[0];

    // Copy sees pre-write active values and pre-write pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shd_q[i] <= '0;
            end
        end else begin
            if (vs_fall && pend_q) begin
                for (int i = 0; i < NREG; i++) begin
                    shd_q[i] <= act_q[i];
                end
            end
            pend_q <= commit | (pend_q & ~vs_fall);
        end
    end

    assign pend_rd = pend_q;
    assign pos     = shd_q;
`else
    assign pend_rd = 1'b0;
    assign pos     = act_q;
`endif

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == 4'(i)) begin
                rdata_d = {{(32-POS_W){act_q[i][POS_W-1]}}, act_q[i]};
            end
        end
        if (addr == 4'd10) begin
            rdata_d = (32'(fcnt_q) << 16) | 32'(pend_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    assign posx1 = pos[0];
    assign posy1 = pos[1];
    assign posx2 = pos[2];
    assign posy2 = pos[3];
    assign posx3 = pos[4];
    assign posy3 = pos[5];
    assign posx4 = pos[6];
    assign posy4 = pos[7];
    assign posx5 = pos[8];
    assign posy5 = pos[9];

endmodule
